// File: rtl/lsu_unit.sv
// RV32I load/store unit: one data-memory transaction per issue over a req/ack
// handshake, with lane steering on stores and lane extract/extend on loads.
module lsu_unit #(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              is_store,
    input  logic [1:0]        size,
    input  logic              unsigned_ld,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    input  logic [4:0]        rd_in,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [4:0]        rd_out,
    output logic              rd_we,
    output logic [31:0]       rdata,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [3:0]        mem_be,
    output logic [31:0]       mem_wdata,
    input  logic              mem_ack,
    input  logic [31:0]       mem_rdata
);

    typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_RESP, S_FAULT} state_t;

    state_t            r_state, w_next;
    logic              r_store, r_uns, r_done, r_err, r_rd_we;
    logic [1:0]        r_size, r_lo;
    logic [4:0]        r_rd, r_rd_out;
    logic [3:0]        r_be, w_be;
    logic [31:0]       r_wdata, w_wdata, r_rdata, w_ld;
    logic [ADDR_W-1:0] r_addr;
    logic              w_bad, w_accept;
    logic [7:0]        w_byte;
    logic [15:0]       w_half;

    assign w_accept = (r_state == S_IDLE) && start;
    assign w_bad    = (size == 2'b11) || (size == 2'b01 && addr[0]) ||
                      (size == 2'b10 && addr[1:0] != 2'b00);

    always_comb begin
        w_be    = 4'b1111;
        w_wdata = wdata;
        case (size)
            2'b00: begin
                w_be    = 4'b0001 << addr[1:0];
                w_wdata = {4{wdata[7:0]}};
            end
            2'b01: begin
                w_be    = addr[1] ? 4'b1100 : 4'b0011;
                w_wdata = {2{wdata[15:0]}};
            end
            default: ;
        endcase
    end

    // Extraction uses the latched low address bits, not the live ALU result
    always_comb begin
        w_byte = mem_rdata[8*r_lo +: 8];
        w_half = mem_rdata[16*r_lo[1] +: 16];
        case (r_size)
            2'b00:   w_ld = {{24{~r_uns & w_byte[7]}}, w_byte};
            2'b01:   w_ld = {{16{~r_uns & w_half[15]}}, w_half};
            default: w_ld = mem_rdata;
        endcase
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (start) w_next = w_bad ? S_FAULT : S_ACCESS;
            S_ACCESS: if (mem_ack) w_next = S_RESP;
            S_RESP:   w_next = S_IDLE;
            S_FAULT:  w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_store  <= 1'b0;
            r_uns    <= 1'b0;
            r_size   <= 2'b00;
            r_lo     <= 2'b00;
            r_rd     <= 5'd0;
            r_be     <= 4'b0000;
            r_wdata  <= 32'd0;
            r_addr   <= '0;
            r_rdata  <= 32'd0;
            r_rd_out <= 5'd0;
            r_done   <= 1'b0;
            r_err    <= 1'b0;
            r_rd_we  <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_store <= is_store;
                r_uns   <= unsigned_ld;
                r_size  <= size;
                r_lo    <= addr[1:0];
                r_rd    <= rd_in;
                r_be    <= w_be;
                r_wdata <= w_wdata;
                r_addr  <= {addr[ADDR_W-1:2], 2'b00};
            end
            if (r_state == S_ACCESS && mem_ack && !r_store)
                r_rdata <= w_ld;
            // Faults complete straight out of IDLE, before r_rd is loaded
            if (w_next == S_RESP || w_next == S_FAULT)
                r_rd_out <= (r_state == S_IDLE) ? rd_in : r_rd;
            r_done  <= (w_next == S_RESP) || (w_next == S_FAULT);
            r_err   <= (w_next == S_FAULT);
            r_rd_we <= (w_next == S_RESP) && !r_store && (r_rd != 5'd0);
        end
    end

    assign busy      = (r_state != S_IDLE);
    assign mem_req   = (r_state == S_ACCESS);
    assign mem_we    = r_store;
    assign mem_addr  = r_addr;
    assign mem_be    = r_be;
    assign mem_wdata = r_wdata;
    assign done      = r_done;
    assign err       = r_err;
    assign rd_we     = r_rd_we;
    assign rd_out    = r_rd_out;
    assign rdata     = r_rdata;

endmodule
